// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/driver stage and the SRAM slave.
// HREADY is the bus-level ready fed back by the interconnect.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADYOUT, HRESP, HREADY
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM array, with configurable
// wait states, byte/halfword/word writes and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_sram_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [2:0]  WAIT_INIT  = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [15:0] RANGE_MASK = 16'hFFFF << (ADDR_W + 2);

  state_t              state;
  logic [2:0]          wait_cnt;
  logic [15:0]         addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic                ready_q;
  logic                resp_q;
  logic                accept;
  logic                illegal;
  logic [3:0]          byte_en;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         mem [2**ADDR_W];

  assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign word_idx = addr_q[ADDR_W+1:2];

  always_comb begin
    illegal = 1'b0;
    if (bus.HSIZE > 3'd2)
      illegal = 1'b1;
    if ((bus.HSIZE == 3'd1) && bus.HADDR[0])
      illegal = 1'b1;
    if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
      illegal = 1'b1;
    if ((bus.HADDR[15:0] & RANGE_MASK) != 16'h0000)
      illegal = 1'b1;
  end

  // IDLE, DATA and ERR2 all sample a new address phase with the same rules,
  // which is what gives back-to-back pipelining.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      addr_q   <= 16'h0000;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      ready_q  <= 1'b1;
      resp_q   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr_q  <= bus.HADDR[15:0];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            if (illegal) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state   <= ST_DATA;
              ready_q <= 1'b1;
              resp_q  <= 1'b0;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
              ready_q  <= 1'b0;
              resp_q   <= 1'b0;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Only a completing DATA phase writes; reset forces IDLE, so an aborted
  // transfer never reaches this commit.
  always_ff @(posedge HCLK) begin
    if ((state == ST_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HRDATA    = ((state == ST_DATA) && !write_q) ? mem[word_idx] : 32'h0000_0000;
  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;

  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR[31:16],
                         bus.HTRANS[0], addr_q};

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave that stores data in a word-organised on-chip SRAM array.
- Connects directly to the team's ahb bus interface through its slave-side signals, and consumes the transfers driven by the master/driver stage.
- Supports a configurable number of wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_W, 10: word-index width; array depth is 2^ADDR_W 32-bit words (4 KB by default).
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase; legal range 0..7.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select, driven by one bit of the decoder's HSEL vector.
- HADDR  in  32  byte address; bits [15:0] are decoded, giving a 64 KB window.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; values greater than 2 are illegal.
- HBURST  in  3  accepted, no effect.
- HPROT  in  4  accepted, no effect.
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTLOCK  in  1  accepted, no effect.
- HREADY  in  1  bus-level ready; qualifies the address phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values:
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - FSM in IDLE; wait counter = 0.
  - Array contents are not reset.
- Transfer acceptance: a transfer is accepted at a rising edge when HSEL && HREADY && HTRANS[1].
  - On acceptance, HADDR[15:0], HWRITE and HSIZE are registered for the data phase.
  - IDLE/BUSY transfers, or cycles with HSEL = 0: FSM stays in IDLE, zero-wait OKAY response.
- Illegal transfer: any one of the following makes a transfer illegal.
  - HSIZE > 2.
  - Halfword with HADDR[0] = 1.
  - Word with HADDR[1:0] != 0.
  - HADDR[15:ADDR_W+2] != 0 (out of range).
- FSM states:
  - IDLE: on a legal acceptance, go to DATA if WAIT_STATES = 0, else go to WAIT with counter = WAIT_STATES-1. On an illegal acceptance, go to ERR1.
  - WAIT: HREADYOUT = 0, HRESP = 0. Counter decrements each cycle; at 0, go to DATA.
  - DATA: HREADYOUT = 1, HRESP = 0; the transfer completes this cycle. The next state is chosen from the address phase sampled in the same cycle, using the IDLE rules (back-to-back pipelining).
  - ERR1: HREADYOUT = 0, HRESP = 1; always go to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. A new address phase sampled here is accepted using the IDLE rules; if the master cancels by driving IDLE, go to IDLE.
- Zero-wait latency: address phase at edge N, data phase completes at edge N+1, so throughput is one transfer per cycle.
- Write commit: happens at the completing edge of DATA, using byte enables derived from the registered size and address.
  - Byte: lane = addr[1:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Data is taken from the matching HWDATA lanes; unenabled bytes are unchanged.
- Read data: during DATA of a read, HRDATA = full word at the registered index; all lanes are driven regardless of size.
  - HRDATA = 0 in every other state.
- Write-then-read, same address, back-to-back: the read returns the newly written data (the write commits before the read's data phase samples the array).
- ERROR transfers never modify the array; HRDATA = 0 throughout.
- Reset asserted mid-transfer: the transfer is aborted with no write, and all outputs return to their reset values immediately.

Test Plan:
- Reset, then write word 0xDEADBEEF to 0x0010, then read 0x0010 (WAIT_STATES=0): HREADYOUT stays 1 and the read data phase returns HRDATA = 0xDEADBEEF, HRESP = 0.
- Write word 0x00000000 to 0x0020, byte 0xAA to 0x0021, halfword 0x1234 to 0x0022, then read 0x0020 -> HRDATA = 0x1234AA00.
- WAIT_STATES=3, NONSEQ read: HREADYOUT is low for exactly 3 cycles, then high for 1 with valid data; the following address phase is held off until that cycle.
- Word write to 0x0006 (misaligned) and a read to 0x2000 (out of range): each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a read-back of 0x0004 is unchanged.
- Back-to-back NONSEQ/SEQ burst of 4 words to 0x0100..0x010C, then a 4-word read burst: one transfer per cycle, data matches; HBURST, HPROT and HMASTLOCK toggling has no effect.
- Assert HRESET during a WAIT-state write: HREADYOUT=1 and HRESP=0 immediately, and the target word retains its old value.
